// File: rtl/inv_debounce_bank.sv
// Bank of input conditioners: 2-flop synchroniser, glitch filter requiring STABLE
// consecutive cycles, per-channel output polarity and one-cycle rise/fall strobes.
module inv_debounce_bank #(
   parameter int CHANNELS = 4,
   parameter int STABLE   = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                en,
   input  logic [CHANNELS-1:0] invert_mask,
   input  logic [CHANNELS-1:0] din,
   output logic [CHANNELS-1:0] dout,
   output logic [CHANNELS-1:0] rise,
   output logic [CHANNELS-1:0] fall,
   output logic                busy
);

   localparam int               CNT_W   = (STABLE > 1) ? $clog2(STABLE) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE - 1);

   logic [CHANNELS-1:0]            sync_p0;
   logic [CHANNELS-1:0]            sync_p1;
   logic [CHANNELS-1:0]            filt_p2;
   logic [CHANNELS-1:0]            rise_p2;
   logic [CHANNELS-1:0]            fall_p2;
   logic [CHANNELS-1:0][CNT_W-1:0] cnt_p2;

   function automatic logic out_level(input logic filt, input logic inv);
      return filt ^ inv;
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_p0 <= '0;
         sync_p1 <= '0;
         filt_p2 <= '0;
         rise_p2 <= '0;
         fall_p2 <= '0;
         cnt_p2  <= '0;
      end else begin
         // stage p0/p1: metastability chain, free-running regardless of en
         sync_p0 <= din;
         sync_p1 <= sync_p0;
         // stage p2: per-channel stability counter and accepted level
         for (int i = 0; i < CHANNELS; i++) begin
            rise_p2[i] <= 1'b0;
            fall_p2[i] <= 1'b0;
            if (!en || (sync_p1[i] == filt_p2[i])) begin
               cnt_p2[i] <= '0;
            end else if (cnt_p2[i] == CNT_MAX) begin
               filt_p2[i] <= sync_p1[i];
               cnt_p2[i]  <= '0;
               rise_p2[i] <= out_level(sync_p1[i], invert_mask[i]);
               fall_p2[i] <= ~out_level(sync_p1[i], invert_mask[i]);
            end else begin
               cnt_p2[i] <= cnt_p2[i] + 1'b1;
            end
         end
      end
   end

   // Polarity is applied after the filter so mask changes never look like edges.
   assign dout = filt_p2 ^ invert_mask;
   assign rise = rise_p2;
   assign fall = fall_p2;
   assign busy = |cnt_p2;

endmodule

// File: tb/tb_inv_debounce_bank.sv
// Bench for inv_debounce_bank: directed table, multi-cycle sequences and random
// stimulus against a run-length reference model, on STABLE=4 and STABLE=1 builds.
module tb_inv_debounce_bank;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       en  = 1'b1;
   logic [3:0] invert_mask = 4'b1010;
   logic [3:0] din = 4'b1111;
   logic [3:0] dout_a, rise_a, fall_a, dout_b, rise_b, fall_b;
   logic       busy_a, busy_b;

   int n_pass  = 0;
   int n_total = 0;

   inv_debounce_bank #(.CHANNELS(4), .STABLE(4)) dut_a (
      .clk(clk), .rst(rst), .en(en), .invert_mask(invert_mask), .din(din),
      .dout(dout_a), .rise(rise_a), .fall(fall_a), .busy(busy_a));

   inv_debounce_bank #(.CHANNELS(4), .STABLE(1)) dut_b (
      .clk(clk), .rst(rst), .en(en), .invert_mask(invert_mask), .din(din),
      .dout(dout_b), .rise(rise_b), .fall(fall_b), .busy(busy_b));

   always #5 clk = ~clk;

   // reference model: index 0 = STABLE 4 build, index 1 = STABLE 1 build
   int stab [2] = '{4, 1};
   bit m_d1   [2][4];
   bit m_d2   [2][4];
   bit m_f    [2][4];
   int m_run  [2][4];
   bit m_r    [2][4];
   bit m_fl   [2][4];

   initial begin
      for (int k = 0; k < 2; k++)
         for (int c = 0; c < 4; c++) begin
            m_d1[k][c] = 0; m_d2[k][c] = 0; m_f[k][c] = 0;
            m_run[k][c] = 0; m_r[k][c] = 0; m_fl[k][c] = 0;
         end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   task automatic model_step(input logic r, input logic e, input logic [3:0] m, input logic [3:0] d);
      bit s;
      for (int k = 0; k < 2; k++)
         for (int c = 0; c < 4; c++) begin
            m_r[k][c]  = 0;
            m_fl[k][c] = 0;
            if (r) begin
               m_d1[k][c] = 0; m_d2[k][c] = 0; m_f[k][c] = 0; m_run[k][c] = 0;
            end else begin
               s = m_d2[k][c];
               m_d2[k][c] = m_d1[k][c];
               m_d1[k][c] = d[c];
               if (!e || s == m_f[k][c]) begin
                  m_run[k][c] = 0;
               end else begin
                  m_run[k][c] = m_run[k][c] + 1;
                  if (m_run[k][c] == stab[k]) begin
                     m_f[k][c] = s;
                     m_run[k][c] = 0;
                     if (s ^ m[c]) m_r[k][c] = 1;
                     else m_fl[k][c] = 1;
                  end
               end
            end
         end
   endtask

   task automatic compare_model();
      logic [3:0] xd [2];
      logic [3:0] xr [2];
      logic [3:0] xf [2];
      logic       xb [2];
      for (int k = 0; k < 2; k++) begin
         xb[k] = 1'b0;
         for (int c = 0; c < 4; c++) begin
            xd[k][c] = m_f[k][c] ^ invert_mask[c];
            xr[k][c] = m_r[k][c];
            xf[k][c] = m_fl[k][c];
            if (m_run[k][c] != 0) xb[k] = 1'b1;
         end
      end
      chk("model_dout_s4", 32'(dout_a), 32'(xd[0]));
      chk("model_rise_s4", 32'(rise_a), 32'(xr[0]));
      chk("model_fall_s4", 32'(fall_a), 32'(xf[0]));
      chk("model_busy_s4", 32'(busy_a), 32'(xb[0]));
      chk("model_dout_s1", 32'(dout_b), 32'(xd[1]));
      chk("model_rise_s1", 32'(rise_b), 32'(xr[1]));
      chk("model_fall_s1", 32'(fall_b), 32'(xf[1]));
      chk("model_busy_s1", 32'(busy_b), 32'(xb[1]));
   endtask

   task automatic tick();
      logic r, e;
      logic [3:0] m, d;
      r = rst; e = en; m = invert_mask; d = din;
      @(posedge clk);
      model_step(r, e, m, d);
      #1;
      compare_model();
   endtask

   typedef struct {
      logic       r;
      logic       e;
      logic [3:0] m;
      logic [3:0] d;
      logic [3:0] xd;
      logic [3:0] xr;
      logic [3:0] xf;
      logic       xb;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(logic r, logic e, logic [3:0] m, logic [3:0] d,
                               logic [3:0] xd, logic [3:0] xr, logic [3:0] xf, logic xb);
      vec_t v;
      v.r = r; v.e = e; v.m = m; v.d = d; v.xd = xd; v.xr = xr; v.xf = xf; v.xb = xb;
      return v;
   endfunction

   initial begin
      int lat_a, lat_b, cnt_r, cnt_f;
      logic seen, bad;
      logic [3:0] first_rise;

      // reset, then inverter mode on ch0: fall after 6 edges, rise after 6 edges back
      tbl.push_back(mk(1, 1, 4'b1010, 4'b1111, 4'b1010, 4'b0000, 4'b0000, 0));
      tbl.push_back(mk(1, 1, 4'b1010, 4'b0000, 4'b1010, 4'b0000, 4'b0000, 0));
      tbl.push_back(mk(0, 1, 4'b0001, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 0));
      tbl.push_back(mk(0, 1, 4'b0001, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 0));
      tbl.push_back(mk(0, 1, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 0));
      tbl.push_back(mk(0, 1, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 0));
      tbl.push_back(mk(0, 1, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 1));
      tbl.push_back(mk(0, 1, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 1));
      tbl.push_back(mk(0, 1, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 1));
      tbl.push_back(mk(0, 1, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 0));
      tbl.push_back(mk(0, 1, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 0));
      tbl.push_back(mk(0, 1, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0));
      tbl.push_back(mk(0, 1, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0));
      tbl.push_back(mk(0, 1, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1));
      tbl.push_back(mk(0, 1, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1));
      tbl.push_back(mk(0, 1, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1));
      tbl.push_back(mk(0, 1, 4'b0001, 4'b0000, 4'b0001, 4'b0001, 4'b0000, 0));
      tbl.push_back(mk(0, 1, 4'b0001, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 0));

      foreach (tbl[i]) begin
         rst = tbl[i].r; en = tbl[i].e; invert_mask = tbl[i].m; din = tbl[i].d;
         tick();
         chk($sformatf("tbl%0d_dout", i), 32'(dout_a), 32'(tbl[i].xd));
         chk($sformatf("tbl%0d_rise", i), 32'(rise_a), 32'(tbl[i].xr));
         chk($sformatf("tbl%0d_fall", i), 32'(fall_a), 32'(tbl[i].xf));
         chk($sformatf("tbl%0d_busy", i), 32'(busy_a), 32'(tbl[i].xb));
      end

      // 3-clock glitch on ch1 is rejected
      invert_mask = 4'b0000;
      seen = 0; bad = 0; cnt_r = 0;
      for (int t = 0; t < 11; t++) begin
         din = (t < 3) ? 4'b0010 : 4'b0000;
         tick();
         if (busy_a) seen = 1;
         if (dout_a[1]) bad = 1;
         if (rise_a[1]) cnt_r++;
      end
      chk("glitch3_busy_seen", 32'(seen), 32'd1);
      chk("glitch3_dout_held", 32'(bad), 32'd0);
      chk("glitch3_no_rise", 32'(cnt_r), 32'd0);
      chk("glitch3_busy_end", 32'(busy_a), 32'd0);

      // 4-clock pulse on ch1 is accepted once, then released
      cnt_r = 0; cnt_f = 0;
      for (int t = 0; t < 16; t++) begin
         din = (t < 4) ? 4'b0010 : 4'b0000;
         tick();
         if (rise_a[1]) cnt_r++;
         if (fall_a[1]) cnt_f++;
      end
      chk("pulse4_rise_once", 32'(cnt_r), 32'd1);
      chk("pulse4_fall_once", 32'(cnt_f), 32'd1);

      // mask flip is combinational and strobe-free
      invert_mask = 4'b1111;
      #1;
      chk("mask_dout_same_cycle", 32'(dout_a), 32'hF);
      bad = 0;
      for (int t = 0; t < 3; t++) begin
         tick();
         if ((rise_a | fall_a) != 4'b0000) bad = 1;
      end
      chk("mask_no_strobe", 32'(bad), 32'd0);
      invert_mask = 4'b0000;

      // enable gating on ch2
      en = 1'b0; din = 4'b0100; bad = 0;
      for (int t = 0; t < 10; t++) begin
         tick();
         if (dout_a[2] || busy_a) bad = 1;
      end
      chk("en0_held", 32'(bad), 32'd0);
      en = 1'b1; lat_a = 0;
      for (int t = 1; t <= 20 && lat_a == 0; t++) begin
         tick();
         if (dout_a[2]) lat_a = t;
      end
      chk("en1_latency", 32'(lat_a), 32'd4);

      din = 4'b0000;
      for (int t = 0; t < 10; t++) tick();

      // simultaneous update on all channels, latency in both builds
      din = 4'b1111; lat_a = 0; lat_b = 0; first_rise = 4'b0000;
      for (int t = 1; t <= 12; t++) begin
         tick();
         if (lat_a == 0 && dout_a == 4'b1111) lat_a = t;
         if (lat_b == 0 && dout_b == 4'b1111) lat_b = t;
         if (first_rise == 4'b0000 && rise_a != 4'b0000) first_rise = rise_a;
      end
      chk("latency_s4", 32'(lat_a), 32'd6);
      chk("latency_s1", 32'(lat_b), 32'd3);
      chk("multi_rise", 32'(first_rise), 32'hF);

      // reset while counters are at 2
      din = 4'b0000;
      for (int t = 0; t < 4; t++) tick();
      chk("midrst_busy_before", 32'(busy_a), 32'd1);
      rst = 1'b1;
      tick();
      chk("midrst_busy", 32'(busy_a), 32'd0);
      chk("midrst_dout", 32'(dout_a), 32'h0);
      chk("midrst_strobe", 32'(rise_a | fall_a), 32'h0);
      rst = 1'b0; bad = 0;
      for (int t = 0; t < 8; t++) begin
         tick();
         if ((rise_a | fall_a) != 4'b0000) bad = 1;
      end
      chk("midrst_no_later_strobe", 32'(bad), 32'd0);

      // random traffic against the model
      for (int t = 0; t < 600; t++) begin
         for (int c = 0; c < 4; c++)
            if ($urandom_range(0, 4) == 0) din[c] = ~din[c];
         en = ($urandom_range(0, 15) != 0);
         if ($urandom_range(0, 31) == 0) invert_mask = 4'($urandom_range(0, 15));
         rst = ($urandom_range(0, 99) == 0);
         tick();
      end
      rst = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/inv_debounce_bank.md
Name: inv_debounce_bank

Overview:
- Parametrised successor to the single-bit CMOS inverter: a bank of CHANNELS inverting input conditioners, each with a per-bit polarity select.
- Each channel synchronises an asynchronous input, rejects glitches shorter than STABLE clocks, and drives a filtered, optionally inverted level plus one-cycle rise/fall strobes.
- Sits between raw lab-board inputs (switches, buttons) and the synchronous logic that consumes them.

Parameters:
- CHANNELS, 4: number of independent channels (≥1).
- STABLE, 4: consecutive synchronised cycles a new level must hold before it is accepted (≥1).
- CNT_W, derived localparam = max(1, $clog2(STABLE)): counter width per channel; not overridable.

Ports:
- clk  input  1  single clock, all state updates on rising edge
- rst  input  1  synchronous reset, active-high
- en  input  1  filter enable
- invert_mask  input  CHANNELS  per channel: 1 = output inverted (inverter mode), 0 = buffer mode
- din  input  CHANNELS  raw asynchronous inputs
- dout  output  CHANNELS  conditioned level = filt XOR invert_mask
- rise  output  CHANNELS  one-cycle strobe when dout goes 0->1 due to a filter update
- fall  output  CHANNELS  one-cycle strobe when dout goes 1->0 due to a filter update
- busy  output  1  1 while any channel counter is non-zero

Behaviour:
- One clock domain. Reset is synchronous and active-high; the clock port is named clk and the reset port rst.
- Reset (rst=1 at an edge), per channel:
  - sync1, sync2, filt, cnt, rise and fall all cleared to 0.
  - Hence dout = invert_mask and busy = 0 after reset.
  - rst has priority over en and all other activity.
  - Reset mid-filter discards partial counts; no strobe is produced.
- Synchroniser: 2-flop chain per channel (sync1 <= din, sync2 <= sync1). It runs regardless of en; only rst clears it.
- Filter, per channel, at each edge with en=1:
  - sync2 == filt: cnt <= 0.
  - sync2 != filt and cnt == STABLE-1: filt <= sync2, cnt <= 0, and the matching strobe fires.
  - sync2 != filt otherwise: cnt <= cnt+1.
- en=0: filt held, cnt <= 0, rise/fall <= 0.
- Latency: if din changes before edge k and holds, filt (and dout) updates at edge k+1+STABLE. For STABLE=4 that is 6 edges.
- Glitch rejection: a sync2 excursion shorter than STABLE cycles never reaches filt; its counter returns to 0 when sync2 matches filt again.
- Strobes:
  - rise[i]/fall[i] are registered and asserted for exactly the cycle after the edge at which filt[i] changes.
  - Direction is judged on dout: new filt XOR invert_mask.
  - Changing invert_mask alters dout combinationally and never generates a strobe.
- Channels are fully independent. Simultaneous updates on several channels produce simultaneous strobes.
- busy = OR over all channels of (cnt != 0), combinational from registers.
- STABLE=1: a new level is accepted on the first edge it is seen on sync2. cnt stays 0, so busy stays 0.
- No arithmetic wrap: cnt never exceeds STABLE-1.

Test Plan (CHANNELS=4, STABLE=4 unless stated):
- Reset: rst=1 for 2 edges with invert_mask=4'b1010 and din=4'b1111 -> dout=4'b1010, rise=fall=0, busy=0. With rst still held, din changes -> no output change.
- Inverter mode, ch0: invert_mask=4'b0001, din[0] 0->1 held before edge k -> dout[0] goes 1->0 at edge k+5 and fall[0]=1 for exactly one cycle. din[0] back to 0 -> dout[0]=1 and rise[0]=1 after 6 edges.
- Glitch: din[1] high for 3 clocks then low -> dout[1] unchanged, no strobe, busy=1 during the excursion then 0. A 4-clock pulse -> accepted, rise[1]=1 once.
- Mask toggle: filt steady, invert_mask flips 0000->1111 -> dout inverts the same cycle, rise=fall=0 throughout.
- Enable gating: en=0 while din[2] is held changed for 10 clocks -> dout[2] held, busy=0. en=1 -> dout[2] updates 4 edges later.
- Multi-channel / mid-op reset:
  - din 0000->1111 together -> rise=1111 in a single cycle.
  - rst asserted at cnt=2 -> cnt=0, filt=0, no strobe.
  - STABLE=1 build -> latency 3 edges.
